// File: rtl/mem_ctl_rr_if.sv
// mem_ctl_rr_if: request, response and byte-bus
// signals shared by the controller and its users.
interface mem_ctl_rr_if #(
  parameter int NCH = 2
);
  logic                 rdy;
  logic [NCH-1:0]       req_valid;
  logic [NCH-1:0]       req_wr;
  logic [2*NCH-1:0]     req_len;
  logic [32*NCH-1:0]    req_addr;
  logic [32*NCH-1:0]    req_wdata;
  logic                 flush;
  logic                 io_buffer_full;
  logic [7:0]           mem_din;
  logic [7:0]           mem_dout;
  logic [31:0]          mem_a;
  logic                 mem_wr;
  logic [NCH-1:0]       resp_valid;
  logic [31:0]          resp_data;
  logic                 busy;

  modport master (
    output rdy, req_valid, req_wr, req_len,
    output req_addr, req_wdata, flush,
    output io_buffer_full, mem_din,
    input  mem_dout, mem_a, mem_wr,
    input  resp_valid, resp_data, busy
  );

  modport slave (
    input  rdy, req_valid, req_wr, req_len,
    input  req_addr, req_wdata, flush,
    input  io_buffer_full, mem_din,
    output mem_dout, mem_a, mem_wr,
    output resp_valid, resp_data, busy
  );
endinterface

// File: rtl/mem_ctl_rr.sv
// mem_ctl_rr: round-robin byte-serial memory
// controller with flush, pause and I/O backpressure.
module mem_ctl_rr #(
  parameter int             NCH        = 2,
  parameter logic [NCH-1:0] FLUSH_MASK = NCH'(1),
  parameter logic [1:0]     IO_HI      = 2'b11
) (
  input logic        clk,
  input logic        rst,
  mem_ctl_rr_if.slave bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    last_q, last_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      data_q, data_d;
  logic [1:0]       lst_q, lst_d;
  logic             io_q, io_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [31:0]      mem_a_q, mem_a_d;
  logic [7:0]       dout_q, dout_d;
  logic             wr_q, wr_d;
  logic [NCH-1:0]   rv_q, rv_d;
  logic [31:0]      rd_q, rd_d;
  logic             busy_q, busy_d;

  logic [NCH-1:0]   elig;
  logic             gnt_ok;
  logic [CW-1:0]    gnt;
  logic [31:0]      g_addr;
  logic [31:0]      g_wdata;
  logic [1:0]       g_len;
  logic [1:0]       bi;

  // Round-robin pick starting after the last grant;
  // a flush hides cancellable channels.
  always_comb begin
    int j;
    j = 0;
    elig = bus.req_valid
         & ~(bus.flush ? FLUSH_MASK : '0);
    gnt_ok = 1'b0;
    gnt = '0;
    for (int i = 1; i <= NCH; i++) begin
      j = (int'(last_q) + i) % NCH;
      if (!gnt_ok && elig[j]) begin
        gnt_ok = 1'b1;
        gnt = CW'(j);
      end
    end
    g_addr  = bus.req_addr[{gnt, 5'b0} +: 32];
    g_wdata = bus.req_wdata[{gnt, 5'b0} +: 32];
    g_len   = bus.req_len[{gnt, 1'b0} +: 2];
  end

  // Next-state logic; everything but the response
  // pulse holds while rdy is low.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    lst_d   = lst_q;
    io_d    = io_q;
    cnt_d   = cnt_q;
    mem_a_d = mem_a_q;
    dout_d  = dout_q;
    wr_d    = wr_q;
    rv_d    = '0;
    rd_d    = rd_q;
    busy_d  = busy_q;
    bi      = 2'(cnt_q - 3'd1);
    if (bus.rdy) begin
      unique case (state_q)
        IDLE: begin
          if (gnt_ok) begin
            last_d  = gnt;
            ch_d    = gnt;
            addr_d  = g_addr;
            wdata_d = g_wdata;
            lst_d   = (g_len == 2'd0) ? 2'd0 :
                      (g_len == 2'd1) ? 2'd1 : 2'd3;
            io_d    = (g_addr[17:16] == IO_HI);
            cnt_d   = '0;
            data_d  = '0;
            busy_d  = 1'b1;
            mem_a_d = g_addr;
            if (bus.req_wr[gnt]) begin
              state_d = WR;
              wr_d    = 1'b1;
              dout_d  = g_wdata[7:0];
            end else begin
              state_d = RD;
            end
          end
        end
        RD: begin
          if (bus.flush && FLUSH_MASK[ch_q]) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            mem_a_d = '0;
          end else begin
            if (cnt_q != 3'd0)
              data_d[{bi, 3'b000} +: 8] = bus.mem_din;
            if (cnt_q == {1'b0, lst_q} + 3'd1) begin
              rv_d[ch_q] = 1'b1;
              rd_d    = data_d;
              state_d = IDLE;
              busy_d  = 1'b0;
              mem_a_d = '0;
            end else begin
              cnt_d   = cnt_q + 3'd1;
              mem_a_d = (cnt_d <= {1'b0, lst_q})
                      ? addr_q + 32'(cnt_d) : '0;
            end
          end
        end
        WR: begin
          if (!(io_q && bus.io_buffer_full)) begin
            if (cnt_q[1:0] == lst_q) begin
              rv_d[ch_q] = 1'b1;
              state_d = IDLE;
              busy_d  = 1'b0;
              mem_a_d = '0;
              wr_d    = 1'b0;
              dout_d  = '0;
            end else begin
              cnt_d   = cnt_q + 3'd1;
              mem_a_d = addr_q + 32'(cnt_d);
              dout_d  = wdata_q[{cnt_d[1:0], 3'b000} +: 8];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= CW'(NCH - 1);
      ch_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      lst_q   <= '0;
      io_q    <= 1'b0;
      cnt_q   <= '0;
      mem_a_q <= '0;
      dout_q  <= '0;
      wr_q    <= 1'b0;
      rv_q    <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      lst_q   <= lst_d;
      io_q    <= io_d;
      cnt_q   <= cnt_d;
      mem_a_q <= mem_a_d;
      dout_q  <= dout_d;
      wr_q    <= wr_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.mem_a      = mem_a_q;
  assign bus.mem_dout   = dout_q;
  assign bus.mem_wr     = wr_q & bus.rdy
                        & ~(io_q & bus.io_buffer_full);
  assign bus.resp_valid = rv_q;
  assign bus.resp_data  = rd_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mem_ctl_rr.sv
// tb_mem_ctl_rr: directed bench for mem_ctl_rr
// with a rdy-gated byte memory model.
module tb_mem_ctl_rr;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   r0 = 0;
  int   r1 = 0;
  logic [39:0] wlog[$];
  logic [7:0]  mem_arr [16];

  mem_ctl_rr_if #(.NCH(2)) bus ();

  mem_ctl_rr #(.NCH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Byte memory: one-cycle registered read, paused with rdy.
  always @(posedge clk)
    if (bus.rdy) bus.mem_din <= mem_arr[bus.mem_a[3:0]];

  // Log bus writes and response pulses.
  always @(posedge clk) begin
    if (bus.mem_wr === 1'b1)
      wlog.push_back({bus.mem_a, bus.mem_dout});
    if (bus.resp_valid[0] === 1'b1) r0++;
    if (bus.resp_valid[1] === 1'b1) r1++;
  end

  task automatic chk(input string tag,
                     input logic [39:0] obs,
                     input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input bit wr,
                         input logic [1:0] len,
                         input logic [31:0] a,
                         input logic [31:0] d);
    bus.req_wr[ch] = wr;
    bus.req_len[2*ch +: 2] = len;
    bus.req_addr[32*ch +: 32] = a;
    bus.req_wdata[32*ch +: 32] = d;
    bus.req_valid[ch] = 1'b1;
  endtask

  initial begin
    logic [1:0] erv;
    for (int i = 0; i < 16; i++) mem_arr[i] = 8'(i);
    mem_arr[0]  = 8'h11;
    mem_arr[1]  = 8'h22;
    mem_arr[2]  = 8'h33;
    mem_arr[3]  = 8'h44;
    mem_arr[15] = 8'hA5;
    bus.rdy = 1'b1;
    bus.req_valid = '0;
    bus.req_wr = '0;
    bus.req_len = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.flush = 1'b0;
    bus.io_buffer_full = 1'b0;
    bus.mem_din = '0;

    tick();
    tick();
    chk("rst_mem_a", bus.mem_a, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_dout", bus.mem_dout, 0);
    chk("rst_rv", bus.resp_valid, 0);
    chk("rst_rdata", bus.resp_data, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b1;
    tick();

    // 4-byte read on ch1
    set_req(1, 0, 2'd2, 32'h100, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rd4_a", bus.mem_a, 32'h100 + k);
      chk("rd4_wr", bus.mem_wr, 0);
      chk("rd4_rv", bus.resp_valid, 0);
    end
    tick();
    chk("rd4_wait_rv", bus.resp_valid, 0);
    tick();
    chk("rd4_rv1", bus.resp_valid, 2'b10);
    chk("rd4_data", bus.resp_data, 32'h44332211);
    bus.req_valid[1] = 1'b0;
    tick();
    chk("rd4_rv_off", bus.resp_valid, 0);
    chk("rd4_idle", bus.busy, 0);
    chk("rd4_a0", bus.mem_a, 0);

    // 2-byte I/O write stalled three cycles
    wlog.delete();
    bus.io_buffer_full = 1'b1;
    set_req(0, 1, 2'd1, 32'h30000, 32'h0000BEEF);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("io_stall_wr", bus.mem_wr, 0);
      chk("io_stall_a", bus.mem_a, 32'h30000);
    end
    tick();
    bus.io_buffer_full = 1'b0;
    #1;
    chk("io_b0_wr", bus.mem_wr, 1);
    chk("io_b0_a", bus.mem_a, 32'h30000);
    chk("io_b0_d", bus.mem_dout, 8'hEF);
    tick();
    chk("io_b1_wr", bus.mem_wr, 1);
    chk("io_b1_a", bus.mem_a, 32'h30001);
    chk("io_b1_d", bus.mem_dout, 8'hBE);
    tick();
    chk("io_ack", bus.resp_valid, 2'b01);
    chk("io_ack_wr", bus.mem_wr, 0);
    bus.req_valid[0] = 1'b0;
    tick();
    chk("io_ack_off", bus.resp_valid, 0);
    chk("io_nwrites", wlog.size(), 2);
    chk("io_log0", wlog[0], {32'h30000, 8'hEF});
    chk("io_log1", wlog[1], {32'h30001, 8'hBE});

    // Continuous 1-byte reads on both channels;
    // last grant was ch0 so ch1 leads.
    set_req(0, 0, 2'd0, 32'h101, 0);
    set_req(1, 0, 2'd0, 32'h102, 0);
    for (int c = 0; c < 12; c++) begin
      tick();
      erv = 2'b00;
      if (c % 3 == 2)
        erv = ((c / 3) % 2 == 0) ? 2'b10 : 2'b01;
      chk("rr_rv", bus.resp_valid, erv);
      chk("rr_busy", bus.busy, (c % 3 == 2) ? 0 : 1);
      if (erv == 2'b10) chk("rr_d1", bus.resp_data, 32'h33);
      if (erv == 2'b01) chk("rr_d0", bus.resp_data, 32'h22);
    end
    bus.req_valid = '0;

    // Flush aborts ch0 read at k=1, ch1 then served
    tick();
    set_req(0, 0, 2'd2, 32'h100, 0);
    tick();
    set_req(1, 0, 2'd0, 32'h103, 0);
    chk("fl_a0", bus.mem_a, 32'h100);
    tick();
    chk("fl_a1", bus.mem_a, 32'h101);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.req_valid[0] = 1'b0;
    #1;
    chk("fl_idle", bus.busy, 0);
    chk("fl_a_zero", bus.mem_a, 0);
    chk("fl_no_rv", bus.resp_valid, 0);
    tick();
    chk("fl_ch1_busy", bus.busy, 1);
    chk("fl_ch1_a", bus.mem_a, 32'h103);
    tick();
    tick();
    chk("fl_ch1_rv", bus.resp_valid, 2'b10);
    chk("fl_ch1_d", bus.resp_data, 32'h44);
    bus.req_valid[1] = 1'b0;

    // Flush in IDLE blocks ch0, then flush on completion
    tick();
    set_req(0, 0, 2'd0, 32'h100, 0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    chk("fli_nogrant", bus.busy, 0);
    tick();
    chk("fli_grant", bus.busy, 1);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.req_valid[0] = 1'b0;
    #1;
    chk("flc_no_rv", bus.resp_valid, 0);
    chk("flc_idle", bus.busy, 0);

    // Pause five cycles mid-read across 0x1FFFF
    tick();
    set_req(1, 0, 2'd1, 32'h1FFFF, 0);
    tick();
    chk("ps_a0", bus.mem_a, 32'h1FFFF);
    tick();
    chk("ps_a1", bus.mem_a, 32'h20000);
    bus.rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ps_hold_a", bus.mem_a, 32'h20000);
      chk("ps_hold_rv", bus.resp_valid, 0);
    end
    tick();
    bus.rdy = 1'b1;
    tick();
    chk("ps_wait_rv", bus.resp_valid, 0);
    tick();
    chk("ps_rv", bus.resp_valid, 2'b10);
    chk("ps_data", bus.resp_data, 32'h000011A5);
    bus.req_valid[1] = 1'b0;

    // Reset during a 4-byte write at k=2
    tick();
    wlog.delete();
    set_req(0, 1, 2'd2, 32'h40, 32'hDDCCBBAA);
    tick();
    chk("rw_b0", bus.mem_dout, 8'hAA);
    tick();
    chk("rw_b1", bus.mem_dout, 8'hBB);
    tick();
    chk("rw_b2_a", bus.mem_a, 32'h42);
    chk("rw_b2_wr", bus.mem_wr, 1);
    rst = 1'b0;
    bus.req_valid[0] = 1'b0;
    #1;
    chk("rw_rst_wr", bus.mem_wr, 0);
    chk("rw_rst_a", bus.mem_a, 0);
    chk("rw_rst_d", bus.mem_dout, 0);
    chk("rw_rst_busy", bus.busy, 0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("rw_nwrites", wlog.size(), 2);
    chk("acks_ch0", r0, 3);
    chk("acks_ch1", r1, 5);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
